// File: rtl/machine_control_pkg.sv
// Shared encodings for the machine-mode trap/return sequencer:
// FSM state codes, PC source select codes, mcause codes and the SYSTEM opcode.
package machine_control_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } mc_state_e;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_NEXT = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_EPC  = 2'b11;

  localparam logic [3:0] CAUSE_MEI   = 4'd11;
  localparam logic [3:0] CAUSE_MSI   = 4'd3;
  localparam logic [3:0] CAUSE_MTI   = 4'd7;
  localparam logic [3:0] CAUSE_IMIS  = 4'd0;
  localparam logic [3:0] CAUSE_ILL   = 4'd2;
  localparam logic [3:0] CAUSE_BRK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;
  localparam logic [3:0] CAUSE_LMIS  = 4'd4;
  localparam logic [3:0] CAUSE_SMIS  = 4'd6;

  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

endpackage

// File: rtl/machine_control_trap_cause_encoder.sv
// Combinational priority encoder: picks the highest-priority trap source
// among the already-masked interrupt requests and the synchronous exception
// flags, and reports its mcause code and interrupt/exception kind.
module trap_cause_encoder
  import machine_control_pkg::*;
(
  input  logic       mei_pend_i,
  input  logic       msi_pend_i,
  input  logic       mti_pend_i,
  input  logic       misaligned_instr_i,
  input  logic       illegal_i,
  input  logic       ebreak_i,
  input  logic       ecall_i,
  input  logic       misaligned_load_i,
  input  logic       misaligned_store_i,
  output logic       trap_req_o,
  output logic [3:0] cause_o,
  output logic       i_or_e_o
);

  // Fixed-priority selection, interrupts ahead of exceptions.
  always_comb begin
    trap_req_o = 1'b1;
    cause_o    = 4'd0;
    i_or_e_o   = 1'b0;
    if (mei_pend_i) begin
      cause_o  = CAUSE_MEI;
      i_or_e_o = 1'b1;
    end else if (msi_pend_i) begin
      cause_o  = CAUSE_MSI;
      i_or_e_o = 1'b1;
    end else if (mti_pend_i) begin
      cause_o  = CAUSE_MTI;
      i_or_e_o = 1'b1;
    end else if (misaligned_instr_i) begin
      cause_o = CAUSE_IMIS;
    end else if (illegal_i) begin
      cause_o = CAUSE_ILL;
    end else if (ebreak_i) begin
      cause_o = CAUSE_BRK;
    end else if (ecall_i) begin
      cause_o = CAUSE_ECALL;
    end else if (misaligned_load_i) begin
      cause_o = CAUSE_LMIS;
    end else if (misaligned_store_i) begin
      cause_o = CAUSE_SMIS;
    end else begin
      trap_req_o = 1'b0;
    end
  end

endmodule

// File: rtl/machine_control.sv
// Machine-mode trap/return sequencer for the RV32I core.
// Optional build macro MC_INTERRUPTS_EN: when defined, the interrupt
// enable/pending inputs can raise traps; otherwise only synchronous
// exceptions and mret move the FSM, and the interrupt ports are ignored.
module machine_control
  import machine_control_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       stall_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

  mc_state_e  state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] cause_q, cause_d;
  logic       i_or_e_q, i_or_e_d;

  logic       sys_base_s, ecall_s, ebreak_s, mret_s;
  logic       mei_pend_s, msi_pend_s, mti_pend_s;
  logic       trap_req_s, enc_i_or_e_s;
  logic [3:0] enc_cause_s;

  // SYSTEM-instruction decodes; all share opcode, funct3, rs1 and rd of zero.
  assign sys_base_s = (opcode_6_to_2_in == OPC_SYSTEM) && (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign ecall_s    = sys_base_s && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
  assign ebreak_s   = sys_base_s && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
  assign mret_s     = sys_base_s && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

`ifdef MC_INTERRUPTS_EN
  assign mei_pend_s = mie_in & meie_in & meip_in;
  assign msi_pend_s = mie_in & msie_in & msip_in;
  assign mti_pend_s = mie_in & mtie_in & mtip_in;
`else
  logic unused_irq_s;
  assign unused_irq_s = ^{mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in};
  assign mei_pend_s   = 1'b0;
  assign msi_pend_s   = 1'b0;
  assign mti_pend_s   = 1'b0;
`endif

  trap_cause_encoder u_enc (
    .mei_pend_i         (mei_pend_s),
    .msi_pend_i         (msi_pend_s),
    .mti_pend_i         (mti_pend_s),
    .misaligned_instr_i (misaligned_instr_in),
    .illegal_i          (illegal_instr_in),
    .ebreak_i           (ebreak_s),
    .ecall_i            (ecall_s),
    .misaligned_load_i  (misaligned_load_in),
    .misaligned_store_i (misaligned_store_in),
    .trap_req_o         (trap_req_s),
    .cause_o            (enc_cause_s),
    .i_or_e_o           (enc_i_or_e_s)
  );

  // State, reset hold counter and latched trap cause.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_RESET;
      hold_cnt_q <= 4'd0;
      cause_q    <= 4'd0;
      i_or_e_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cause_q    <= cause_d;
      i_or_e_q   <= i_or_e_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    cause_d         = cause_q;
    i_or_e_d        = i_or_e_q;
    pc_src_out      = PC_SRC_BOOT;
    flush_out       = 1'b1;
    trap_taken_out  = 1'b0;
    set_cause_out   = 1'b0;
    set_epc_out     = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (state_q)
      ST_RESET: begin
        hold_cnt_d = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_OPERATING;
        end else begin
          state_d = ST_RESET;
        end
      end
      ST_OPERATING: begin
        pc_src_out      = PC_SRC_NEXT;
        flush_out       = 1'b0;
        instret_inc_out = ~stall_in;
        // A stalled cycle freezes the decision; traps win over mret.
        if (stall_in) begin
          state_d = ST_OPERATING;
        end else if (trap_req_s) begin
          state_d  = ST_TRAP_TAKEN;
          cause_d  = enc_cause_s;
          i_or_e_d = enc_i_or_e_s;
        end else if (mret_s) begin
          state_d = ST_TRAP_RETURN;
        end else begin
          state_d = ST_OPERATING;
        end
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = PC_SRC_TRAP;
        trap_taken_out = 1'b1;
        set_cause_out  = 1'b1;
        set_epc_out    = 1'b1;
        mie_clear_out  = 1'b1;
        state_d        = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_SRC_EPC;
        mie_set_out = 1'b1;
        state_d     = ST_OPERATING;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign cause_out  = cause_q;
  assign i_or_e_out = i_or_e_q;

endmodule

// File: tb/tb_machine_control.sv
// Directed self-checking bench for machine_control (RESET_HOLD_CYCLES = 1).
// Interrupt-dependent expectations follow the MC_INTERRUPTS_EN build macro.
module tb_machine_control;

  logic       clk_in = 1'b0;
  logic       rst_in, stall_in;
  logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
  logic [4:0] opcode_6_to_2_in, rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic [1:0] pc_src_out;
  logic       flush_out, trap_taken_out, i_or_e_out, set_cause_out, set_epc_out;
  logic       mie_clear_out, mie_set_out, instret_inc_out;
  logic [3:0] cause_out;

  int n_cmp = 0;
  int n_bad = 0;

  machine_control #(.RESET_HOLD_CYCLES(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .pc_src_out(pc_src_out), .flush_out(flush_out), .trap_taken_out(trap_taken_out),
    .i_or_e_out(i_or_e_out), .cause_out(cause_out), .set_cause_out(set_cause_out),
    .set_epc_out(set_epc_out), .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .instret_inc_out(instret_inc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    illegal_instr_in = 1'b0; misaligned_instr_in = 1'b0;
    misaligned_load_in = 1'b0; misaligned_store_in = 1'b0;
    opcode_6_to_2_in = 5'd0; funct3_in = 3'd0; funct7_in = 7'd0;
    rs1_addr_in = 5'd0; rs2_addr_in = 5'd0; rd_addr_in = 5'd0;
    mie_in = 1'b0; meie_in = 1'b0; mtie_in = 1'b0; msie_in = 1'b0;
    meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
  endtask

  task automatic set_sys(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rd);
    opcode_6_to_2_in = 5'b11100; funct3_in = 3'd0; funct7_in = f7;
    rs1_addr_in = 5'd0; rs2_addr_in = rs2; rd_addr_in = rd;
  endtask

  // Advance into the trap cycle, check it, then return to OPERATING.
  task automatic exp_trap(input string tag, input logic [3:0] cause, input logic ior);
    step();
    chk({tag, "_pc"}, pc_src_out, 2'b10);
    chk({tag, "_trap"}, trap_taken_out, 1'b1);
    chk({tag, "_cause"}, cause_out, cause);
    chk({tag, "_ior"}, i_or_e_out, ior);
    chk({tag, "_strb"}, {flush_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out, instret_inc_out},
        6'b111100);
    clear_in();
    step();
    chk({tag, "_back"}, {pc_src_out, flush_out, instret_inc_out, cause_out}, {2'b01, 1'b0, 1'b1, cause});
  endtask

  // Advance into the mret cycle, check it, then return to OPERATING.
  task automatic exp_ret(input string tag);
    step();
    chk({tag, "_pc"}, pc_src_out, 2'b11);
    chk({tag, "_strb"}, {flush_out, trap_taken_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out, instret_inc_out},
        7'b1000010);
    clear_in();
    step();
    chk({tag, "_back"}, pc_src_out, 2'b01);
  endtask

  initial begin
    clear_in();
    rst_in = 1'b1;
    stall_in = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    // Still in RESET for one cycle after deassertion.
    chk("rst_pc", pc_src_out, 2'b00);
    chk("rst_strb", {flush_out, trap_taken_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out, instret_inc_out},
        7'b1000000);
    chk("rst_cause", {i_or_e_out, cause_out}, 5'd0);
    step();
    chk("op_pc", pc_src_out, 2'b01);
    chk("op_strb", {flush_out, instret_inc_out}, 2'b01);

    // Illegal instruction.
    illegal_instr_in = 1'b1;
    exp_trap("ill", 4'd2, 1'b0);

    // Misaligned fetch beats illegal; lone store misalignment.
    misaligned_instr_in = 1'b1; illegal_instr_in = 1'b1;
    exp_trap("imis", 4'd0, 1'b0);
    misaligned_store_in = 1'b1;
    exp_trap("smis", 4'd6, 1'b0);

    // ecall / ebreak; ecall with nonzero rd is not a trap.
    set_sys(7'd0, 5'd0, 5'd0);
    exp_trap("ecall", 4'd11, 1'b0);
    set_sys(7'd0, 5'd1, 5'd0);
    exp_trap("ebrk", 4'd3, 1'b0);
    set_sys(7'd0, 5'd0, 5'd1);
    step();
    chk("ecall_rd", {pc_src_out, trap_taken_out, instret_inc_out}, {2'b01, 1'b0, 1'b1});
    clear_in();

    // Interrupt priority over a load misalignment.
    mie_in = 1'b1; meie_in = 1'b1; mtie_in = 1'b1; meip_in = 1'b1; mtip_in = 1'b1;
    misaligned_load_in = 1'b1;
`ifdef MC_INTERRUPTS_EN
    exp_trap("pri_mei", 4'd11, 1'b1);
`else
    exp_trap("pri_mei", 4'd4, 1'b0);
`endif
    mie_in = 1'b1; meie_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1;
    misaligned_load_in = 1'b1;
`ifdef MC_INTERRUPTS_EN
    exp_trap("pri_mti", 4'd7, 1'b1);
`else
    exp_trap("pri_mti", 4'd4, 1'b0);
`endif

    // mret, then mret racing a software interrupt.
    set_sys(7'b0011000, 5'd2, 5'd0);
    exp_ret("mret");
    set_sys(7'b0011000, 5'd2, 5'd0);
    mie_in = 1'b1; msie_in = 1'b1; msip_in = 1'b1;
`ifdef MC_INTERRUPTS_EN
    exp_trap("mret_msi", 4'd3, 1'b1);
`else
    exp_ret("mret_msi");
`endif

    // Stall freezes OPERATING; release lets the trap through.
    stall_in = 1'b1; illegal_instr_in = 1'b1;
    #1;
    chk("stall_inc", instret_inc_out, 1'b0);
    step();
    chk("stall_hold", {pc_src_out, trap_taken_out, flush_out, instret_inc_out}, {2'b01, 1'b0, 1'b0, 1'b0});
    step();
    chk("stall_hold2", {pc_src_out, trap_taken_out}, {2'b01, 1'b0});
    stall_in = 1'b0;
    exp_trap("stall_rel", 4'd2, 1'b0);

    // Reset during TRAP_TAKEN.
    misaligned_load_in = 1'b1;
    step();
    chk("mid_trap", trap_taken_out, 1'b1);
    chk("mid_cause", cause_out, 4'd4);
    clear_in();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mid_rst_pc", pc_src_out, 2'b00);
    chk("mid_rst_strb", {flush_out, trap_taken_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out, instret_inc_out},
        7'b1000000);
    chk("mid_rst_cause", {i_or_e_out, cause_out}, 5'd0);
    step();
    chk("mid_rst_op", {pc_src_out, instret_inc_out}, {2'b01, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
